rv32i_multicycle_ctrl: RTL and testbench
========================================

// Module: rv32i_multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the RV32I core: sequences fetch/decode/execute/memory/writeback.
//  Drives cu_immtype into the immediate generator and steers PC, register file, ALU and memory.
//  Sits between the instruction register and the datapath; replaces the single-cycle decoder.
// PARAMETERS
//  MEM_WAIT_MAX  16  max cycles req may stay high without ready before bus_err; 0 = no timeout
// PORTS
//  clk          in   1   core clock; all state updates on rising edge
//  rst_n        in   1   synchronous reset, active-low
//  instr        in   32  current instruction from IR (valid from DECODE onward)
//  br_taken     in   1   branch-compare result from ALU (sampled in EXEC)
//  imem_ready   in   1   instruction memory data valid
//  dmem_ready   in   1   data memory access complete
//  imem_req     out  1   instruction fetch request
//  dmem_req     out  1   data memory request
//  dmem_we      out  1   1 = store, 0 = load (valid only while dmem_req=1)
//  ir_we        out  1   latch instr into IR
//  pc_we        out  1   update PC
//  pc_sel       out  2   00 PC+4, 01 PC+imm, 10 ALU result & ~1 (JALR)
//  rf_we        out  1   register file write enable
//  wb_sel       out  2   00 ALU, 01 memory data, 10 PC+4, 11 imm (LUI)
//  alu_src_a    out  1   0 rs1, 1 PC (AUIPC)
//  alu_src_b    out  1   0 rs2, 1 imm
//  alu_op       out  4   ALU function, from funct3/funct7[5]; ADD for load/store/AUIPC/JALR
//  cu_immtype   out  3   I=000 S=001 B=010 U=011 J=100; R-type/unknown drive 000
//  bus_err      out  1   one-cycle pulse on memory timeout
//  illegal      out  1   sticky illegal-instruction flag (CTRL_ILLEGAL_TRAP_EN only)
// BEHAVIOUR
//  States (3b): FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5. Moore outputs from state + instr.
//  Reset: rst_n=0 at an edge -> state FETCH, wait counter 0, illegal 0. Every output is 0
//   while rst_n=0, including mid-access; in-flight memory transactions are abandoned.
//  FETCH: imem_req=1; on imem_ready: ir_we=1 same cycle, -> DECODE.
//  DECODE: cu_immtype/alu_op valid; no strobes; -> EXEC unconditionally (1 cycle).
//  EXEC by opcode:
//   BRANCH(1100011): pc_we=1, pc_sel = br_taken ? 01 : 00; -> FETCH.
//   JAL(1101111): rf_we=1 wb_sel=10, pc_we=1 pc_sel=01; -> FETCH.
//   JALR(1100111): rf_we=1 wb_sel=10, pc_we=1 pc_sel=10; -> FETCH.
//   LOAD(0000011)/STORE(0100011): alu_src_b=1, alu_op=ADD; -> MEM.
//   OP/OP-IMM/LUI/AUIPC: -> WB. FENCE/SYSTEM: pc_we=1 pc_sel=00 (NOP); -> FETCH.
//   other opcode: NOP as FENCE unless CTRL_ILLEGAL_TRAP_EN.
//  MEM: dmem_req=1, dmem_we=store; on dmem_ready: store -> pc_we=1 pc_sel=00, -> FETCH;
//   load -> WB. Address/data operands held stable for the whole MEM state.
//  WB: rf_we=1, wb_sel per class (load 01, LUI 11, else 00), pc_we=1 pc_sel=00; -> FETCH.
//  rd=x0: rf_we still asserted; x0 discard is the register file's job.
//  Wait counter: increments each FETCH/MEM cycle with req=1 and ready=0; clears on state change.
//   MEM_WAIT_MAX>0 and count==MEM_WAIT_MAX-1 with ready still 0: bus_err=1 that cycle,
//   -> FETCH, no pc_we/rf_we/ir_we (instruction retried). ready in that cycle wins over timeout.
//  Latency (zero-wait memory): ALU/LUI/AUIPC 4, load 5, store 4, branch/jump 3 cycles.
// CONFIGURATION
//  `CTRL_ILLEGAL_TRAP_EN defined: unknown opcode, or SYSTEM with funct3!=000, in EXEC -> TRAP;
//   TRAP holds all strobes 0, illegal=1, exits only on reset.
//  Undefined: illegal tied 0, TRAP unreachable, unknown opcodes execute as NOP.
// STRUCTURE
//  Shared header rv32i_ctrl_defs.vh: opcode, immtype, state, pc_sel, wb_sel, alu_op encodings.
//  Sub-module rv32i_main_decoder: combinational opcode/funct -> class, cu_immtype, alu_op.
//  Top holds state register, wait counter, illegal flag, output decode.
// TESTING
//  ADDI x1,x0,5 (0x00500093), zero-wait mem -> states 0,1,2,4; rf_we in WB; cu_immtype=000.
//  SW x1,8(x2), dmem_ready after 3 cycles -> dmem_req 4 cycles, dmem_we=1, cu_immtype=001.
//  BEQ br_taken=1 -> pc_sel=01, pc_we in EXEC; br_taken=0 -> pc_sel=00; cu_immtype=010.
//  MEM_WAIT_MAX=4, imem_ready stuck 0 -> bus_err pulse in 4th req cycle, FETCH re-entered, pc_we=0.
//  rst_n=0 during MEM of LW -> next cycle state FETCH, dmem_req=0, no rf_we.
//  Opcode 0x7F: with macro -> TRAP, illegal=1 held; without -> pc_we pc_sel=00, back to FETCH.

Source files
------------

// File: rtl/rv32i_multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller:
// FSM states, opcodes, instruction classes, immtype, pc_sel, wb_sel, alu_op.
package rv32i_multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      CL_OP,
      CL_OPIMM,
      CL_LUI,
      CL_AUIPC,
      CL_LOAD,
      CL_STORE,
      CL_BRANCH,
      CL_JAL,
      CL_JALR,
      CL_NOP,
      CL_ILL
   } iclass_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_IMM   = 2'b01;
   localparam logic [1:0] PC_ALU   = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
   localparam logic [1:0] WB_IMM = 2'b11;

   // alu_op = {funct7[5], funct3}
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;

   function automatic logic [1:0] wb_sel_of(iclass_e c);
      logic [1:0] s;
      s = WB_ALU;
      if (c == CL_LOAD) s = WB_MEM;
      if (c == CL_LUI)  s = WB_IMM;
      return s;
   endfunction

endpackage

// File: rtl/rv32i_multicycle_ctrl_decoder.sv
// Combinational main decoder: instr -> class, cu_immtype, alu_op.
// Ports: instr in; iclass, immtype, alu_op out.
module rv32i_multicycle_ctrl_decoder
   import rv32i_multicycle_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output iclass_e     iclass,
   output logic [2:0]  immtype,
   output logic [3:0]  alu_op
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic       f7b;
   logic       unused_bits;

   assign opc = instr[6:0];
   assign f3  = instr[14:12];
   assign f7b = instr[30];
   assign unused_bits =
      ^{instr[31], instr[29:15], instr[11:7]};

   always_comb begin
      iclass  = CL_ILL;
      immtype = IMM_I;
      alu_op  = ALU_ADD;
      unique case (1'b1)
         (opc == OPC_OP): begin
            iclass = CL_OP;
            alu_op = {f7b, f3};
         end
         (opc == OPC_OPIMM): begin
            iclass = CL_OPIMM;
            // only SRAI carries funct7[5]
            alu_op = {f7b & (f3 == 3'b101), f3};
         end
         (opc == OPC_LUI): begin
            iclass  = CL_LUI;
            immtype = IMM_U;
         end
         (opc == OPC_AUIPC): begin
            iclass  = CL_AUIPC;
            immtype = IMM_U;
         end
         (opc == OPC_LOAD): begin
            iclass = CL_LOAD;
         end
         (opc == OPC_STORE): begin
            iclass  = CL_STORE;
            immtype = IMM_S;
         end
         (opc == OPC_BRANCH): begin
            // compare via SUB; ALU picks condition from funct3
            iclass  = CL_BRANCH;
            immtype = IMM_B;
            alu_op  = ALU_SUB;
         end
         (opc == OPC_JAL): begin
            iclass  = CL_JAL;
            immtype = IMM_J;
         end
         (opc == OPC_JALR): begin
            iclass = CL_JALR;
         end
         (opc == OPC_FENCE): begin
            iclass = CL_NOP;
         end
         (opc == OPC_SYSTEM): begin
            iclass = (f3 == 3'b000) ? CL_NOP : CL_ILL;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// RV32I multi-cycle control FSM: fetch/decode/exec/mem/wb.
// Ports: clk, rst_n, instr, br_taken, imem_ready, dmem_ready in;
//   imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we,
//   wb_sel, alu_src_a, alu_src_b, alu_op, cu_immtype, bus_err,
//   illegal out. Optional macro: CTRL_ILLEGAL_TRAP_EN.
module rv32i_multicycle_ctrl
   import rv32i_multicycle_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 16
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        br_taken,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        alu_src_a,
   output logic        alu_src_b,
   output logic [3:0]  alu_op,
   output logic [2:0]  cu_immtype,
   output logic        bus_err,
   output logic        illegal
);

   localparam int CW =
      (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
   localparam logic [CW-1:0] CNT_LAST =
      CW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);
   localparam bit TO_EN = (MEM_WAIT_MAX > 0);

`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   state_e        state_q;
   state_e        state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   iclass_e       iclass;
   logic [2:0]    dec_imm;
   logic [3:0]    dec_aluop;
   logic          mem_act;
   logic          mem_rdy;
   logic          timeout;

   rv32i_multicycle_ctrl_decoder u_dec (
      .instr   (instr),
      .iclass  (iclass),
      .immtype (dec_imm),
      .alu_op  (dec_aluop)
   );

   assign mem_act = (state_q == S_FETCH) ||
                    (state_q == S_MEM);
   assign mem_rdy = (state_q == S_FETCH) ?
                    imem_ready : dmem_ready;
   // ready in the last allowed cycle beats the timeout
   assign timeout = TO_EN && mem_act && !mem_rdy &&
                    (cnt_q == CNT_LAST);

   always_comb begin
      state_d    = state_q;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = PC_PLUS4;
      rf_we      = 1'b0;
      wb_sel     = WB_ALU;
      alu_src_a  = 1'b0;
      alu_src_b  = 1'b0;
      alu_op     = ALU_ADD;
      cu_immtype = IMM_I;
      bus_err    = 1'b0;
      // everything stays at its default while in reset
      if (rst_n) begin
         unique case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_we   = 1'b1;
                  state_d = S_DECODE;
               end else if (timeout) begin
                  bus_err = 1'b1;
               end
            end
            S_DECODE: begin
               state_d = S_EXEC;
            end
            S_EXEC: begin
               state_d = S_FETCH;
               unique case (iclass)
                  CL_BRANCH: begin
                     pc_we  = 1'b1;
                     pc_sel = br_taken ? PC_IMM : PC_PLUS4;
                  end
                  CL_JAL: begin
                     rf_we  = 1'b1;
                     wb_sel = WB_PC4;
                     pc_we  = 1'b1;
                     pc_sel = PC_IMM;
                  end
                  CL_JALR: begin
                     rf_we  = 1'b1;
                     wb_sel = WB_PC4;
                     pc_we  = 1'b1;
                     pc_sel = PC_ALU;
                  end
                  CL_LOAD, CL_STORE: begin
                     state_d = S_MEM;
                  end
                  CL_OP, CL_OPIMM, CL_LUI, CL_AUIPC: begin
                     state_d = S_WB;
                  end
                  CL_ILL: begin
                     if (TRAP_EN) state_d = S_TRAP;
                     else         pc_we   = 1'b1;
                  end
                  default: begin
                     pc_we = 1'b1;
                  end
               endcase
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (iclass == CL_STORE);
               if (dmem_ready) begin
                  if (iclass == CL_STORE) begin
                     pc_we   = 1'b1;
                     state_d = S_FETCH;
                  end else begin
                     state_d = S_WB;
                  end
               end else if (timeout) begin
                  // abandon; instruction is refetched
                  bus_err = 1'b1;
                  state_d = S_FETCH;
               end
            end
            S_WB: begin
               rf_we   = 1'b1;
               wb_sel  = wb_sel_of(iclass);
               pc_we   = 1'b1;
               state_d = S_FETCH;
            end
            S_TRAP: ;
            default: begin
               state_d = S_FETCH;
            end
         endcase
         if (state_q inside {S_DECODE, S_EXEC,
                             S_MEM, S_WB}) begin
            cu_immtype = dec_imm;
            alu_op     = dec_aluop;
         end
         // operand muxes held from EXEC through WB
         if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
            alu_src_a = (iclass == CL_AUIPC);
            alu_src_b = iclass inside {CL_OPIMM, CL_LOAD,
                                       CL_STORE, CL_LUI,
                                       CL_AUIPC, CL_JALR};
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if ((state_d != state_q) || timeout)
         cnt_d = '0;
      else if (mem_act && !mem_rdy)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic ill_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         ill_q <= 1'b0;
      else if (state_d == S_TRAP)
         ill_q <= 1'b1;
   end

   assign illegal = ill_q & rst_n;
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Self-checking bench for rv32i_multicycle_ctrl.
// Random instruction stream against a per-instruction cycle model.
module tb_rv32i_multicycle_ctrl;
   import rv32i_multicycle_ctrl_pkg::*;

   typedef struct packed {
      logic       ill;
      logic       berr;
      logic       ireq;
      logic       dreq;
      logic       dwe;
      logic       irwe;
      logic       pcwe;
      logic [1:0] pcsel;
      logic       rfwe;
      logic [1:0] wbsel;
   } o_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic        br_taken = 1'b0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        imem_req, dmem_req, dmem_we, ir_we;
   logic        pc_we, rf_we, alu_src_a, alu_src_b;
   logic        bus_err, illegal;
   logic [1:0]  pc_sel, wb_sel;
   logic [3:0]  alu_op;
   logic [2:0]  cu_immtype;

   int n_chk = 0;
   int n_fail = 0;

   localparam int K_OP = 0, K_OPI = 1, K_LUI = 2;
   localparam int K_AUI = 3, K_LD = 4, K_ST = 5;
   localparam int K_BR = 6, K_JAL = 7, K_JALR = 8;
   localparam int K_NOP = 9, K_BAD = 10;

   rv32i_multicycle_ctrl #(.MEM_WAIT_MAX(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr      (instr),
      .br_taken   (br_taken),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .imem_req   (imem_req),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .pc_sel     (pc_sel),
      .rf_we      (rf_we),
      .wb_sel     (wb_sel),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .cu_immtype (cu_immtype),
      .bus_err    (bus_err),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   // select fields only matter while their enable is set
   function automatic o_t obs();
      o_t o;
      o.ill   = illegal;
      o.berr  = bus_err;
      o.ireq  = imem_req;
      o.dreq  = dmem_req;
      o.dwe   = dmem_req & dmem_we;
      o.irwe  = ir_we;
      o.pcwe  = pc_we;
      o.pcsel = pc_we ? pc_sel : 2'b00;
      o.rfwe  = rf_we;
      o.wbsel = rf_we ? wb_sel : 2'b00;
      return o;
   endfunction

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic step(input logic [31:0] ins,
                       input bit ir, input bit dr,
                       input bit br, input o_t e,
                       input string tag,
                       input bit rs = 1'b1);
      @(posedge clk);
      #1;
      rst_n      = rs;
      instr      = ins;
      imem_ready = ir;
      dmem_ready = dr;
      br_taken   = br;
      @(negedge clk);
      check(tag, {20'b0, obs()}, {20'b0, e});
   endtask

   function automatic int kind(logic [31:0] ins);
      int k;
      case (ins[6:0])
         7'b0110011: k = K_OP;
         7'b0010011: k = K_OPI;
         7'b0110111: k = K_LUI;
         7'b0010111: k = K_AUI;
         7'b0000011: k = K_LD;
         7'b0100011: k = K_ST;
         7'b1100011: k = K_BR;
         7'b1101111: k = K_JAL;
         7'b1100111: k = K_JALR;
         7'b0001111: k = K_NOP;
         7'b1110011:
            k = (ins[14:12] == 3'b000) ? K_NOP : K_BAD;
         default:    k = K_BAD;
      endcase
      return k;
   endfunction

   function automatic logic [2:0] imm_of(int k);
      logic [2:0] t;
      t = 3'b000;
      if (k == K_ST) t = 3'b001;
      if (k == K_BR) t = 3'b010;
      if (k == K_LUI || k == K_AUI) t = 3'b011;
      if (k == K_JAL) t = 3'b100;
      return t;
   endfunction

   function automatic logic [3:0] aop_of(logic [31:0] ins,
                                         int k);
      logic [3:0] a;
      a = 4'b0000;
      if (k == K_OP) a = {ins[30], ins[14:12]};
      if (k == K_OPI)
         a = {ins[30] & (ins[14:12] == 3'b101),
              ins[14:12]};
      return a;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  opcs [11];
      logic [6:0]  bad  [6];
      logic [31:0] r;
      opcs = '{7'b0110011, 7'b0010011, 7'b0110111,
               7'b0010111, 7'b0000011, 7'b0100011,
               7'b1100011, 7'b1101111, 7'b1100111,
               7'b0001111, 7'b1110011};
      bad  = '{7'h7F, 7'h0B, 7'h2B, 7'h5B, 7'h7B, 7'h00};
      r = $urandom;
`ifdef CTRL_ILLEGAL_TRAP_EN
      r[6:0] = opcs[$urandom_range(0, 10)];
      if (r[6:0] == 7'b1110011) r[14:12] = 3'b000;
`else
      if ($urandom_range(0, 11) == 11)
         r[6:0] = bad[$urandom_range(0, 5)];
      else
         r[6:0] = opcs[$urandom_range(0, 10)];
`endif
      return r;
   endfunction

   // dw >= 0: data wait cycles; -1: data timeout;
   // -2: reset during MEM. brv 0/1 forces br_taken, 2 random.
   task automatic run_instr(input logic [31:0] ins,
                            input int iw, input int dw,
                            input int brv);
      int k;
      bit st, br, trap;
      o_t e;
      k  = kind(ins);
      st = (k == K_ST);
`ifdef CTRL_ILLEGAL_TRAP_EN
      trap = (k == K_BAD);
`else
      trap = 1'b0;
`endif
      for (int i = 0; i < iw; i++) begin
         e = '0; e.ireq = 1'b1;
         step($urandom, 1'b0, rb(), rb(), e, "fetch_wait");
      end
      e = '0; e.ireq = 1'b1; e.irwe = 1'b1;
      step(ins, 1'b1, rb(), rb(), e, "fetch");
      e = '0;
      step(ins, rb(), rb(), rb(), e, "decode");
      check("immtype", 32'(cu_immtype), 32'(imm_of(k)));
      if (k != K_BR)
         check("aluop", 32'(alu_op), 32'(aop_of(ins, k)));
      br = (brv == 2) ? rb() : 1'(brv);
      e = '0;
      case (k)
         K_BR: begin
            e.pcwe = 1'b1;
            e.pcsel = br ? 2'b01 : 2'b00;
         end
         K_JAL: begin
            e.rfwe = 1'b1; e.wbsel = 2'b10;
            e.pcwe = 1'b1; e.pcsel = 2'b01;
         end
         K_JALR: begin
            e.rfwe = 1'b1; e.wbsel = 2'b10;
            e.pcwe = 1'b1; e.pcsel = 2'b10;
         end
         K_NOP: e.pcwe = 1'b1;
         K_BAD: e.pcwe = !trap;
         default: ;
      endcase
      step(ins, rb(), rb(), br, e, "exec");
      if (k inside {K_OP, K_OPI, K_AUI, K_LD, K_ST})
         check("src", {30'b0, alu_src_a, alu_src_b},
               {30'b0, k == K_AUI, k != K_OP});
      if (trap) begin
         for (int i = 0; i < 3; i++) begin
            e = '0; e.ill = 1'b1;
            step(ins, rb(), rb(), rb(), e, "trap");
         end
         e = '0;
         step(ins, 1'b1, 1'b1, 1'b1, e, "trap_rst", 1'b0);
         return;
      end
      if (k == K_LD || k == K_ST) begin
         e = '0; e.dreq = 1'b1; e.dwe = st;
         if (dw == -2) begin
            step(ins, rb(), 1'b0, rb(), e, "mem");
            e = '0;
            step(ins, 1'b1, 1'b1, 1'b1, e, "mem_rst", 1'b0);
            return;
         end
         if (dw == -1) begin
            for (int i = 0; i < 4; i++) begin
               e.berr = (i == 3);
               step(ins, rb(), 1'b0, rb(), e, "mem_to");
            end
            return;
         end
         for (int i = 0; i < dw; i++) begin
            step(ins, rb(), 1'b0, rb(), e, "mem_wait");
            check("mem_opnd", {28'b0, alu_op}, 32'd0);
         end
         e.pcwe = st;
         step(ins, rb(), 1'b1, rb(), e, "mem_done");
         check("mem_srcb", 32'(alu_src_b), 32'd1);
      end
      if (k inside {K_OP, K_OPI, K_LUI, K_AUI, K_LD}) begin
         e = '0; e.rfwe = 1'b1; e.pcwe = 1'b1;
         e.wbsel = (k == K_LD)  ? 2'b01 :
                   (k == K_LUI) ? 2'b11 : 2'b00;
         step(ins, rb(), rb(), rb(), e, "wb");
      end
   endtask

   initial begin
      o_t e;
      e = '0;
      for (int i = 0; i < 3; i++)
         step(32'h00500093, 1'b1, 1'b1, 1'b1, e,
              "reset", 1'b0);
      run_instr(32'h00500093, 0, 0, 2);
      run_instr(32'h00112423, 0, 3, 2);
      run_instr(32'h00000463, 0, 0, 1);
      run_instr(32'h00000463, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         e = '0; e.ireq = 1'b1;
         e.berr = (i == 3) || (i == 7);
         step($urandom, 1'b0, rb(), rb(), e, "fetch_to");
      end
      run_instr(32'h00812083, 3, -1, 2);
      run_instr(32'h00812083, 1, -2, 2);
      run_instr(32'h0000007F, 0, 0, 2);
      run_instr(32'h40208033, 0, 0, 2);
      for (int n = 0; n < 150; n++)
         run_instr(rand_instr(), $urandom_range(0, 3),
                   $urandom_range(0, 3), 2);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
